// File: rtl/softmax_norm_pkg.sv
// Shared types and fixed-point widths for the softmax normalization stage.
package softmax_norm_pkg;

  // Row controller phases: collect a row, compute 1/sum, stream the scaled row.
  typedef enum logic [1:0] {
    FILL = 2'd0,
    DIV  = 2'd1,
    EMIT = 2'd2
  } state_t;

  localparam int EXP_W      = 8;   // exponent input, unsigned Q1.6 (0..127)
  localparam int PROB_W     = 8;   // probability output, unsigned Q0.8
  localparam int RECIP_W    = 16;  // reciprocal of the row sum, scaled by 65536
  localparam int DIV_CYCLES = 17;  // one quotient bit per cycle for 65536 / sum

endpackage

// File: rtl/softmax_norm_if.sv
// Streaming bus of the softmax normalization stage: valid/ready input side,
// credit-controlled output side.
interface softmax_norm_if;
  import softmax_norm_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [EXP_W-1:0]  in_data;
  logic              out_valid;
  logic [PROB_W-1:0] out_data;
  logic              out_last;
  logic              credit_in;

  // Normalizer side.
  modport slave (
    input  in_valid, in_data, credit_in,
    output in_ready, out_valid, out_data, out_last
  );

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, in_data, credit_in,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/softmax_norm_recip_div.sv
// Restoring divider computing floor(65536 / divisor), one quotient bit per
// cycle. The first bit is resolved in the start cycle, so the full 17-bit
// quotient is known at the edge where done is high; the saturated result is
// registered there. A zero divisor yields 0.
module recip_div
  import softmax_norm_pkg::*;
#(
  parameter int DW = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DW-1:0]      divisor,
  output logic               done,
  output logic [RECIP_W-1:0] result
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  logic [DW-1:0]         div_reg;
  logic [DW-1:0]         rem_reg;
  logic [RECIP_W-1:0]    quot_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  busy_reg;

  logic [DW-1:0]         step_div;
  logic [DW:0]           trial;
  logic                  qbit;
  logic [DW-1:0]         rem_next;
  logic [DIV_CYCLES-1:0] quot_full;

  // One restoring step: only the leading dividend bit is 1, all later bits are 0.
  always_comb begin
    step_div  = start ? divisor : div_reg;
    trial     = start ? (DW + 1)'(1) : {rem_reg, 1'b0};
    qbit      = (trial >= {1'b0, step_div});
    rem_next  = qbit ? DW'(trial - {1'b0, step_div}) : DW'(trial);
    quot_full = {quot_reg, qbit};
    done      = busy_reg && (cnt_reg == CNT_W'(1));
  end

  // Iteration state and the saturated result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg  <= '0;
      rem_reg  <= '0;
      quot_reg <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      result   <= '0;
    end else if (start) begin
      div_reg  <= divisor;
      rem_reg  <= rem_next;
      quot_reg <= RECIP_W'(qbit);
      cnt_reg  <= CNT_W'(DIV_CYCLES - 1);
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      rem_reg  <= rem_next;
      quot_reg <= quot_full[RECIP_W-1:0];
      cnt_reg  <= cnt_reg - CNT_W'(1);
      if (done) begin
        busy_reg <= 1'b0;
        if (div_reg == '0)
          result <= '0;
        else if (quot_full[DIV_CYCLES-1])
          result <= '1;
        else
          result <= quot_full[RECIP_W-1:0];
      end
    end
  end

endmodule

// File: rtl/softmax_norm.sv
// Softmax normalization: buffers a row of exponent values while summing them,
// computes 65536/sum with a serial divider, then emits each element scaled by
// the reciprocal as a Q0.8 probability, paced by downstream credits.
module softmax_norm
  import softmax_norm_pkg::*;
#(
  parameter int ROW_LEN = 8,
  parameter int CREDITS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  softmax_norm_if.slave bus
);

  localparam int IDX_W  = $clog2(ROW_LEN);
  localparam int SUM_W  = (EXP_W - 1) + IDX_W;  // 127 * ROW_LEN cannot overflow
  localparam int CNT_W  = $clog2(CREDITS + 1);
  localparam int PROD_W = EXP_W + RECIP_W;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg;
  logic [SUM_W-1:0]   sum_reg;
  logic [CNT_W-1:0]   credit_cnt_reg;
  logic               in_ready_reg;
  logic               div_start_reg;
  logic [EXP_W-1:0]   buffer [ROW_LEN];

  logic               take;
  logic               emit;
  logic               last_idx;
  logic               div_done;
  logic [RECIP_W-1:0] recip;
  logic [PROD_W-1:0]  product;
  logic [RECIP_W-1:0] scaled;

  recip_div #(
    .DW (SUM_W)
  ) u_recip_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start_reg),
    .divisor (sum_reg),
    .done    (div_done),
    .result  (recip)
  );

  assign bus.in_ready = in_ready_reg;

  // Transfer/emit qualifiers and the scaled value of the current element.
  always_comb begin
    take     = bus.in_valid && in_ready_reg;
    last_idx = (idx_reg == IDX_W'(ROW_LEN - 1));
    emit     = (state_reg == EMIT) && (credit_cnt_reg != '0);
    product  = PROD_W'(buffer[idx_reg]) * PROD_W'(recip);
    scaled   = RECIP_W'(product >> PROB_W);
  end

  // Next-state and output decode; outputs stay zero unless an element is emitted.
  always_comb begin
    state_next    = state_reg;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    case (state_reg)
      FILL: begin
        if (take && last_idx)
          state_next = DIV;
      end
      DIV: begin
        if (div_done)
          state_next = EMIT;
      end
      EMIT: begin
        if (emit) begin
          bus.out_valid = 1'b1;
          bus.out_data  = (|scaled[RECIP_W-1:PROB_W]) ? '1 : scaled[PROB_W-1:0];
          bus.out_last  = last_idx;
          if (last_idx)
            state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Phase, element index, running sum and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= FILL;
      in_ready_reg  <= 1'b0;
      div_start_reg <= 1'b0;
      idx_reg       <= '0;
      sum_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next == FILL);
      div_start_reg <= take && last_idx;
      if (take || emit)
        idx_reg <= last_idx ? '0 : idx_reg + IDX_W'(1);
      if (take)
        sum_reg <= sum_reg + SUM_W'(bus.in_data);
      else if (emit && last_idx)
        sum_reg <= '0;
    end
  end

  // Downstream credits: spend one per output, regain one per returned credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      credit_cnt_reg <= CNT_W'(CREDITS);
    else if (emit && !bus.credit_in)
      credit_cnt_reg <= credit_cnt_reg - CNT_W'(1);
    else if (!emit && bus.credit_in && (credit_cnt_reg != CNT_W'(CREDITS)))
      credit_cnt_reg <= credit_cnt_reg + CNT_W'(1);
  end

  // Row storage; every slot is rewritten before it is read again.
  always_ff @(posedge clk) begin
    if (take)
      buffer[idx_reg] <= bus.in_data;
  end

endmodule

// File: doc/softmax_norm.md
SOFTMAX_NORM -- requirements
Module: softmax_norm

Interface
REQ-001 SHALL have parameter ROW_LEN, default 8: number of exponent values per softmax row; ROW_LEN >= 2.
REQ-002 SHALL have parameter CREDITS, default 4: number of downstream credits available after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream exponent value is valid this cycle.
REQ-006 in_ready  output  1  block accepts an input this cycle.
REQ-007 in_data  input  8  exponent value from the exp stage, unsigned Q1.6, range 0..127.
REQ-008 out_valid  output  1  one-cycle pulse; out_data/out_last are valid.
REQ-009 out_data  output  8  normalized probability, unsigned Q0.8.
REQ-010 out_last  output  1  marks the final element of a row.
REQ-011 credit_in  input  1  downstream returns one credit this cycle.

Function
REQ-012 SHALL run a three-state FSM: FILL -> DIV -> EMIT -> FILL.
REQ-013 FILL: in_ready = 1; a transfer occurs when in_valid and in_ready are both 1; the value is stored at buffer[idx] and added to sum; idx increments.
REQ-014 sum width SHALL be 7 + clog2(ROW_LEN) bits (10 bits at default) and SHALL never overflow.
REQ-015 The accepted transfer with idx = ROW_LEN-1 SHALL move the FSM to DIV in the next cycle; in_ready SHALL be 0 outside FILL.
REQ-016 DIV: recip = floor(65536 / sum), saturated to 65535; sum = 0 SHALL give recip = 0. The divider SHALL take exactly 17 cycles regardless of operand, then the FSM SHALL enter EMIT.
REQ-017 EMIT: at most one output per cycle, and only while credit_cnt > 0; element k SHALL be out_data = min(255, (buffer[k] * recip) >> 8), where the product is 24 bits.
REQ-018 out_last SHALL be 1 only for k = ROW_LEN-1; after that output the FSM SHALL return to FILL, with idx and sum cleared.
REQ-019 Elements SHALL be emitted in arrival order; out_data and out_last SHALL be 0 whenever out_valid = 0.
REQ-020 credit_cnt SHALL decrement on each out_valid and increment on each credit_in.
REQ-021 When out_valid and credit_in occur in the same cycle, credit_cnt SHALL be unchanged.
REQ-022 credit_cnt SHALL saturate at CREDITS; excess credit_in SHALL be ignored.
REQ-023 A credit returned in cycle t SHALL be usable for an output in cycle t+1.
REQ-024 The first EMIT output SHALL appear no earlier than 18 cycles after the last input transfer, and exactly then when credit_cnt > 0.

Reset
REQ-025 While rst_n = 0, the FSM SHALL be in FILL with idx = 0, sum = 0, recip = 0 and credit_cnt = CREDITS.
REQ-026 While rst_n = 0, outputs SHALL be out_valid = 0, out_data = 0, out_last = 0 and in_ready = 0.
REQ-027 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-028 Reset asserted mid-row (any state) SHALL discard the partial row and any unfinished division; after reset, no stale output SHALL appear.
REQ-029 Buffer contents need no reset.

Structure
REQ-030 A shared package SHALL hold: the FSM state enum (FILL, DIV, EMIT), the Q-format widths (EXP_W = 8, PROB_W = 8, RECIP_W = 16) and the divider length DIV_CYCLES = 17.
REQ-031 The divider SHALL be a sub-module recip_div: a restoring divider, one quotient bit per cycle, with a start/done handshake and a saturating 16-bit result.
REQ-032 The buffer SHALL be a register array of ROW_LEN x 8 bits.

Verification
REQ-033 Uniform row: eight inputs of 64 -> sum 512, recip 128, eight outputs of 32, out_last on the 8th.
REQ-034 Dominant value: inputs 127,0,0,0,0,0,0,0 -> recip 516; outputs 255, then seven 0s.
REQ-035 All-zero row -> recip 0; eight outputs of 0, with out_last on the 8th; no hang.
REQ-036 Credits: CREDITS = 4, no credit_in -> exactly 4 outputs, then stall; one credit_in -> exactly one further output one cycle later; credit_in coincident with an output -> count unchanged.
REQ-037 Back-to-back rows with in_valid held at 1 -> in_ready is 0 during DIV and EMIT; the second row is unaffected by the first (sum restarts at 0).
REQ-038 rst_n pulsed low after the 3rd output of a row -> no further outputs; in_ready = 1 after reset; a new row of 64s yields 32s.
